ru_wb_arbiter: RTL and testbench
================================

Name: ru_wb_arbiter

Overview:
- Owns the single register-unit write port.
- Shares that port between two requesters:
  - the core writeback path, i.e. the output of the write-data source mux;
  - a multi-cycle unit (MDU: mul/div) that returns results asynchronously.
- Buffers MDU results in a small FIFO and keeps a pending-destination scoreboard.
- Raises a stall to the core on RAW/WAW hazards against outstanding MDU results, and on MDU starvation.

Parameters:
- XLEN, 32, data width.
- RA_W, 5, register address width (32 registers).
- FIFO_DEPTH, 2, MDU result buffer entries (power of two, >=2).
- STARVE_LIMIT, 4, cycles a FIFO head may wait before the core is force-stalled.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- core_wr_en  in  1  core requests a writeback this cycle.
- core_rd  in  RA_W  core destination register.
- core_wrdata  in  XLEN  core writeback data (mux output).
- rs1_used, rs2_used  in  1 each  current instruction reads rs1 / rs2.
- rs1_addr, rs2_addr  in  RA_W each  source registers of the current instruction.
- mdu_issue  in  1  core issues an MDU op this cycle.
- mdu_issue_rd  in  RA_W  destination of the issued MDU op.
- mdu_valid  in  1  MDU result available.
- mdu_ready  out  1  arbiter accepts the MDU result.
- mdu_rd  in  RA_W  MDU result destination.
- mdu_data  in  XLEN  MDU result.
- stall  out  1  core must hold PC; no architectural effect this cycle.
- ru_we  out  1  register-unit write enable.
- ru_addr  out  RA_W  register-unit write address.
- ru_wrdata  out  XLEN  register-unit write data.
- busy  out  1  FIFO non-empty or any scoreboard bit set.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO empties, scoreboard clears to all 0, starve counter goes to 0.
  - While rst_n=0, the outputs are forced: stall=0, ru_we=0, mdu_ready=0, busy=0, ru_addr=0, ru_wrdata=0.
  - A reset in the middle of an operation discards buffered results and pending bits.
- Scoreboard:
  - pend[i] is set at the edge where mdu_issue=1, stall=0 and mdu_issue_rd=i!=0.
  - pend[i] is cleared at the edge where the FIFO head with rd=i is written to the RU.
  - pend[0] is always 0.
- FIFO:
  - mdu_ready = !full. There is no pass-through: a result is accepted only into the FIFO.
  - A push occurs when mdu_valid && mdu_ready.
  - Push and pop may happen in the same cycle.
  - An entry holds {rd, data}. The head is visible the cycle after its push.
- Stall is the combinational OR of:
  - rs1_used && pend[rs1_addr];
  - rs2_used && pend[rs2_addr];
  - core_wr_en && pend[core_rd];
  - mdu_issue && pend[mdu_issue_rd];
  - force_drain.
- core_go = core_wr_en && !stall && core_rd!=0.
- Port grant:
  - If core_go: ru_we=1, ru_addr=core_rd, ru_wrdata=core_wrdata.
  - Else if the FIFO is non-empty: pop the head, with ru_we = (head.rd!=0), ru_addr=head.rd, ru_wrdata=head.data. A head with rd=0 is popped and dropped.
  - Else ru_we=0, and ru_addr/ru_wrdata are 0.
- The write takes effect at the next clk edge (same-cycle with the core, zero added latency).
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and the head is not popped.
  - It resets to 0 on a pop or when the FIFO is empty.
  - force_drain = (count >= STARVE_LIMIT-1) && FIFO non-empty. This stalls the core for one cycle so that the head pops.
- An MDU result whose rd is not pending is still written. No error is flagged.
- An MDU issue to the same rd as a pending entry stalls until that entry drains (no duplicate pending).

Decomposition:
- Package ru_wb_pkg holds:
  - constants XLEN and RA_W;
  - typedef wb_entry_t, a packed struct {logic [RA_W-1:0] rd; logic [XLEN-1:0] data}.
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t with push/pop, full, empty and head outputs.
- The scoreboard, stall logic, starve counter and grant mux live in the top module.

Test Plan:
- Core only: core_wr_en=1, core_rd=5, data=0x1234, FIFO empty -> ru_we=1, ru_addr=5, ru_wrdata=0x1234, stall=0; with core_rd=0 -> ru_we=0.
- RAW hazard:
  - mdu_issue with rd=7, then the next instruction has rs1_used=1, rs1_addr=7 -> stall=1.
  - The MDU returns {7, 0xCAFE}, the core writes nothing, the head pops with ru_we=1, ru_addr=7, ru_wrdata=0xCAFE.
  - The following cycle -> pend[7]=0, stall=0.
- Core priority:
  - FIFO holds {3, 0xAA} and the core writes rd=4 -> the core wins (ru_addr=4).
  - The head pops on the first cycle with no core write.
- Starvation: FIFO head {9, 0x55}, core_wr_en=1 every cycle with rd!=9 -> stall=1 exactly in cycle STARVE_LIMIT (4th cycle); the head pops that cycle; the counter returns to 0.
- FIFO full:
  - Two results pushed while the core writes continuously -> mdu_ready=0.
  - A third mdu_valid holds until a pop; a simultaneous push+pop keeps the count at 2.
- Reset mid-operation:
  - Setup: pend[7]=1 and FIFO holds 1 entry; drive rst_n=0 for one edge.
  - Required: busy=0, pend cleared, FIFO empty; after release mdu_ready=1 and stall=0 for rs1_addr=7.

Source files
------------

// File: rtl/ru_wb_pkg.sv
// Shared constants and the write-back entry type for the register-unit write arbiter.
package ru_wb_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding MDU results until the register-unit port is free.
module wb_fifo
    import ru_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t      mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        head  = mem[rd_ptr[AW-1:0]];
    end

endmodule

// File: rtl/ru_wb_arbiter.sv
// Shares the single register-unit write port between core writeback and buffered MDU results,
// tracking outstanding MDU destinations and stalling the core on hazards or MDU starvation.
module ru_wb_arbiter
    import ru_wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            core_wr_en,
    input  logic [RA_W-1:0] core_rd,
    input  logic [XLEN-1:0] core_wrdata,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic [RA_W-1:0] rs1_addr,
    input  logic [RA_W-1:0] rs2_addr,
    input  logic            mdu_issue,
    input  logic [RA_W-1:0] mdu_issue_rd,
    input  logic            mdu_valid,
    output logic            mdu_ready,
    input  logic [RA_W-1:0] mdu_rd,
    input  logic [XLEN-1:0] mdu_data,
    output logic            stall,
    output logic            ru_we,
    output logic [RA_W-1:0] ru_addr,
    output logic [XLEN-1:0] ru_wrdata,
    output logic            busy
);

    localparam int NREG = 1 << RA_W;
    localparam int CW   = $clog2(STARVE_LIMIT) + 1;

    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic [CW-1:0]   starve_cnt;

    wb_entry_t head;
    wb_entry_t push_entry;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;
    logic      force_drain;
    logic      hazard;
    logic      stall_int;
    logic      core_go;

    always_comb begin
        push_entry.rd   = mdu_rd;
        push_entry.data = mdu_data;
    end

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        force_drain = !empty && (starve_cnt >= CW'(STARVE_LIMIT - 1));
        hazard      = (rs1_used   && pend[rs1_addr])
                   || (rs2_used   && pend[rs2_addr])
                   || (core_wr_en && pend[core_rd])
                   || (mdu_issue  && pend[mdu_issue_rd]);
        stall_int   = hazard || force_drain;
        core_go     = core_wr_en && !stall_int && (core_rd != '0);
        // The head drains on any cycle the core leaves the port free.
        pop         = rst_n && !empty && !core_go;
        push        = rst_n && mdu_valid && !full;
    end

    always_comb begin
        stall     = 1'b0;
        mdu_ready = 1'b0;
        busy      = 1'b0;
        ru_we     = 1'b0;
        ru_addr   = '0;
        ru_wrdata = '0;
        if (rst_n) begin
            stall     = stall_int;
            mdu_ready = !full;
            busy      = !empty || (|pend);
            if (core_go) begin
                ru_we     = 1'b1;
                ru_addr   = core_rd;
                ru_wrdata = core_wrdata;
            end else if (!empty) begin
                ru_we     = (head.rd != '0);
                ru_addr   = head.rd;
                ru_wrdata = head.data;
            end
        end
    end

    always_comb begin
        pend_nxt = pend;
        if (pop) begin
            pend_nxt[head.rd] = 1'b0;
        end
        if (mdu_issue && !stall_int && (mdu_issue_rd != '0)) begin
            pend_nxt[mdu_issue_rd] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // Force-drain guarantees a pop at LIMIT-1, so the counter never needs saturation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend       <= '0;
            starve_cnt <= '0;
        end else begin
            pend <= pend_nxt;
            if (empty || pop) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ru_wb_arbiter.sv
// Self-checking bench for ru_wb_arbiter: vector table, directed corner sequences and a
// randomized run, all compared against a queue-based reference model.
module tb_ru_wb_arbiter;
    import ru_wb_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            core_wr_en;
    logic [RA_W-1:0] core_rd;
    logic [XLEN-1:0] core_wrdata;
    logic            rs1_used, rs2_used;
    logic [RA_W-1:0] rs1_addr, rs2_addr;
    logic            mdu_issue;
    logic [RA_W-1:0] mdu_issue_rd;
    logic            mdu_valid;
    logic            mdu_ready;
    logic [RA_W-1:0] mdu_rd;
    logic [XLEN-1:0] mdu_data;
    logic            stall, ru_we, busy;
    logic [RA_W-1:0] ru_addr;
    logic [XLEN-1:0] ru_wrdata;

    always #5 clk = ~clk;

    ru_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_wr_en(core_wr_en), .core_rd(core_rd), .core_wrdata(core_wrdata),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .stall(stall), .ru_we(ru_we), .ru_addr(ru_addr), .ru_wrdata(ru_wrdata), .busy(busy)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state: result queue, pending bitmap, starvation age of the head.
    wb_entry_t mq[$];
    bit [31:0] mpend;
    int        mstarve;

    logic            e_stall, e_we, e_ready, e_busy, e_pop;
    logic [RA_W-1:0] e_addr;
    logic [XLEN-1:0] e_data;

    function void model_eval();
        wb_entry_t h;
        e_stall = 0; e_we = 0; e_ready = 0; e_busy = 0; e_pop = 0; e_addr = '0; e_data = '0;
        if (rst_n) begin
            e_ready = (mq.size() < DEPTH);
            e_busy  = (mq.size() != 0) || (mpend != 0);
            e_stall = (rs1_used && mpend[rs1_addr]) || (rs2_used && mpend[rs2_addr])
                   || (core_wr_en && mpend[core_rd]) || (mdu_issue && mpend[mdu_issue_rd])
                   || ((mq.size() != 0) && (mstarve >= LIMIT - 1));
            if (core_wr_en && !e_stall && core_rd != 0) begin
                e_we = 1; e_addr = core_rd; e_data = core_wrdata;
            end else if (mq.size() != 0) begin
                h = mq[0];
                e_pop = 1; e_we = (h.rd != 0); e_addr = h.rd; e_data = h.data;
            end
        end
    endfunction

    function void model_update();
        wb_entry_t n;
        if (!rst_n) begin
            mq.delete(); mpend = 0; mstarve = 0;
        end else begin
            if (mq.size() != 0 && !e_pop) mstarve++;
            else mstarve = 0;
            if (e_pop) begin
                mpend[mq[0].rd] = 1'b0;
                void'(mq.pop_front());
            end
            if (mdu_valid && e_ready) begin
                n.rd = mdu_rd; n.data = mdu_data;
                mq.push_back(n);
            end
            if (mdu_issue && !e_stall && mdu_issue_rd != 0) mpend[mdu_issue_rd] = 1'b1;
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_total++;
        if (act !== exp_v) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        else n_pass++;
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
        chk("stall", stall, e_stall);
        chk("ru_we", ru_we, e_we);
        chk("ru_addr", ru_addr, e_addr);
        chk("ru_wrdata", ru_wrdata, e_data);
        chk("mdu_ready", mdu_ready, e_ready);
        chk("busy", busy, e_busy);
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic idle();
        core_wr_en = 0; core_rd = '0; core_wrdata = '0;
        rs1_used = 0; rs2_used = 0; rs1_addr = '0; rs2_addr = '0;
        mdu_issue = 0; mdu_issue_rd = '0; mdu_valid = 0; mdu_rd = '0; mdu_data = '0;
    endtask

    typedef struct {
        logic            wr;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] d;
        logic            x_we;
        logic [RA_W-1:0] x_addr;
        logic [XLEN-1:0] x_data;
        logic            x_stall;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{1'b1, 5'd5,  32'h0000_1234, 1'b1, 5'd5,  32'h0000_1234, 1'b0};
        tbl[1] = '{1'b1, 5'd0,  32'h0000_9999, 1'b0, 5'd0,  32'h0,         1'b0};
        tbl[2] = '{1'b0, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0,         1'b0};
        tbl[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0};
        tbl[4] = '{1'b1, 5'd1,  32'h0,         1'b1, 5'd1,  32'h0,         1'b0};

        idle();
        rst_n = 0;
        settle();
        chk("rst_ready", mdu_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        adv();
        step();
        rst_n = 1;

        // Core-only vectors, FIFO empty and nothing pending.
        for (int i = 0; i < 5; i++) begin
            idle();
            core_wr_en = tbl[i].wr; core_rd = tbl[i].rd; core_wrdata = tbl[i].d;
            settle();
            chk("vec_we", ru_we, tbl[i].x_we);
            chk("vec_addr", ru_addr, tbl[i].x_addr);
            chk("vec_data", ru_wrdata, tbl[i].x_data);
            chk("vec_stall", stall, tbl[i].x_stall);
            adv();
        end

        // RAW hazard on an outstanding MDU destination.
        idle(); mdu_issue = 1; mdu_issue_rd = 5'd7;
        settle(); chk("raw_issue_stall", stall, 1'b0); adv();
        idle(); rs1_used = 1; rs1_addr = 5'd7;
        settle(); chk("raw_stall", stall, 1'b1); adv();
        mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'hCAFE;
        settle(); chk("raw_wait_we", ru_we, 1'b0); adv();
        mdu_valid = 0;
        settle();
        chk("raw_pop_we", ru_we, 1'b1);
        chk("raw_pop_addr", ru_addr, 5'd7);
        chk("raw_pop_data", ru_wrdata, 32'hCAFE);
        adv();
        settle(); chk("raw_clear_stall", stall, 1'b0); chk("raw_clear_busy", busy, 1'b0); adv();

        // Core has priority over a buffered result.
        idle(); mdu_valid = 1; mdu_rd = 5'd3; mdu_data = 32'hAA; step();
        idle(); core_wr_en = 1; core_rd = 5'd4; core_wrdata = 32'h44;
        settle(); chk("prio_core_addr", ru_addr, 5'd4); adv();
        idle();
        settle(); chk("prio_head_addr", ru_addr, 5'd3); chk("prio_head_data", ru_wrdata, 32'hAA); adv();

        // Starvation: head force-drains on the LIMIT-th cycle of continuous core writes.
        idle(); mdu_valid = 1; mdu_rd = 5'd9; mdu_data = 32'h55; step();
        idle(); core_wr_en = 1; core_rd = 5'd10; core_wrdata = 32'h10;
        for (int c = 1; c <= LIMIT + 1; c++) begin
            settle();
            chk("starve_stall", stall, (c == LIMIT));
            chk("starve_addr", ru_addr, (c == LIMIT) ? 5'd9 : 5'd10);
            adv();
        end

        // FIFO fill while the core writes continuously; third result waits for space.
        for (int c = 0; c < 10; c++) begin
            mdu_valid = 1; mdu_rd = 5'(11 + mq.size() + c); mdu_data = 32'(c);
            settle();
            if (c == 2) chk("full_ready", mdu_ready, 1'b0);
            adv();
        end
        core_wr_en = 0;
        for (int c = 0; c < 4; c++) step();
        idle();
        for (int c = 0; c < 4; c++) step();

        // Reset in the middle of an operation.
        idle(); core_wr_en = 1; core_rd = 5'd10; mdu_issue = 1; mdu_issue_rd = 5'd7; step();
        mdu_issue = 0; mdu_valid = 1; mdu_rd = 5'd7; mdu_data = 32'h77; step();
        mdu_valid = 0;
        settle(); chk("pre_rst_busy", busy, 1'b1); adv();
        rst_n = 0;
        settle(); chk("mid_rst_busy", busy, 1'b0); chk("mid_rst_ready", mdu_ready, 1'b0); adv();
        rst_n = 1; idle(); rs1_used = 1; rs1_addr = 5'd7;
        settle();
        chk("post_rst_stall", stall, 1'b0);
        chk("post_rst_ready", mdu_ready, 1'b1);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_we", ru_we, 1'b0);
        adv();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n        = ($urandom_range(0, 99) != 0);
            core_wr_en   = $urandom_range(0, 1);
            core_rd      = 5'($urandom_range(0, 7));
            core_wrdata  = $urandom;
            rs1_used     = $urandom_range(0, 1);
            rs2_used     = $urandom_range(0, 1);
            rs1_addr     = 5'($urandom_range(0, 7));
            rs2_addr     = 5'($urandom_range(0, 7));
            mdu_issue    = ($urandom_range(0, 3) == 0);
            mdu_issue_rd = 5'($urandom_range(0, 7));
            mdu_valid    = ($urandom_range(0, 2) == 0);
            mdu_rd       = 5'($urandom_range(0, 7));
            mdu_data     = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
